// File: rtl/text_buffer_pkg.sv
// Shared types and constants for the character-cell text buffer.
// FSM state enum, stream control codes and the blank-cell code.
package text_buffer_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// text_ram: simple dual-port RAM, synchronous write, registered read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module text_ram #(
    parameter int ADDR_BITS = 13,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    // Read samples the array before this edge's write lands,
    // so a same-cell read/write returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character-cell frame buffer behind the ascii_font57 engine.
// Ports: clk, reset (sync, active-high); char_x/char_y/ascii_char from
// the font engine; char_valid/char_data/char_ready stream input;
// cursor_x/cursor_y cursor position; vsync (blink); out video pixel.
// Optional: define TEXT_BUFFER_CURSOR_EN for a blinking inverted cursor.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int COLS       = 106,
    parameter int ROWS       = 60,
    parameter int COL_BITS   = 7,
    parameter int ROW_BITS   = 6,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          char_x,
    input  logic [7:0]          char_y,
    input  logic [255:0]        ascii_char,
    input  logic                vsync,
    input  logic                char_valid,
    input  logic [7:0]          char_data,
    output logic                char_ready,
    output logic [COL_BITS-1:0] cursor_x,
    output logic [ROW_BITS-1:0] cursor_y,
    output logic                out
);

    localparam int AW = ROW_BITS + COL_BITS;
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

    state_t              state, state_n;
    logic [COL_BITS-1:0] clr_col, clr_col_n;
    logic [ROW_BITS-1:0] clr_row, clr_row_n;
    logic [COL_BITS-1:0] cx_n;
    logic [ROW_BITS-1:0] cy_n;

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic [AW-1:0] raddr;
    logic [7:0]    code_q;
    logic          in_range_q;
    logic          invert;

    function automatic logic [ROW_BITS-1:0] row_inc(
        input logic [ROW_BITS-1:0] r
    );
        return (r == ROW_LAST) ? '0 : r + 1'b1;
    endfunction

    assign char_ready = (state == IDLE);

    always_comb begin
        state_n   = state;
        clr_col_n = clr_col;
        clr_row_n = clr_row;
        cx_n      = cursor_x;
        cy_n      = cursor_y;
        we        = 1'b0;
        waddr     = {clr_row, clr_col};
        wdata     = SPACE;
        unique case (state)
            CLEAR: begin
                we = 1'b1;
                if (clr_col == COL_LAST) begin
                    clr_col_n = '0;
                    if (clr_row == ROW_LAST) begin
                        clr_row_n = '0;
                        state_n   = IDLE;
                        cx_n      = '0;
                        cy_n      = '0;
                    end else begin
                        clr_row_n = clr_row + 1'b1;
                    end
                end else begin
                    clr_col_n = clr_col + 1'b1;
                end
            end
            IDLE: begin
                if (char_valid) begin
                    unique case (1'b1)
                        is_printable(char_data): begin
                            we    = 1'b1;
                            waddr = {cursor_y, cursor_x};
                            wdata = char_data;
                            if (cursor_x == COL_LAST) begin
                                cx_n = '0;
                                cy_n = row_inc(cursor_y);
                            end else begin
                                cx_n = cursor_x + 1'b1;
                            end
                        end
                        (char_data == CC_LF): begin
                            cx_n = '0;
                            cy_n = row_inc(cursor_y);
                        end
                        (char_data == CC_CR): begin
                            cx_n = '0;
                        end
                        (char_data == CC_FF): begin
                            state_n   = CLEAR;
                            clr_col_n = '0;
                            clr_row_n = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_col  <= '0;
            clr_row  <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            state    <= state_n;
            clr_col  <= clr_col_n;
            clr_row  <= clr_row_n;
            cursor_x <= cx_n;
            cursor_y <= cy_n;
        end
    end

    assign raddr = {char_y[ROW_BITS-1:0], char_x[COL_BITS-1:0]};

    text_ram #(
        .ADDR_BITS(AW),
        .DATA_BITS(8)
    ) u_ram (
        .clk  (clk),
        .we   (we & ~reset),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(code_q)
    );

    // Stage 1: in-range flag travels with the registered RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_range_q <= 1'b0;
        end else begin
            in_range_q <= (char_x < 8'(COLS)) && (char_y < 8'(ROWS));
        end
    end

`ifdef TEXT_BUFFER_CURSOR_EN
    logic                vsync_q;
    logic [BLINK_LOG2:0] blink_cnt;
    logic                hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            blink_cnt <= '0;
            hit_q     <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (vsync & ~vsync_q) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            hit_q <= (state == IDLE)
                  && (char_x == 8'(cursor_x))
                  && (char_y == 8'(cursor_y));
        end
    end

    assign invert = blink_cnt[BLINK_LOG2] & hit_q;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign invert       = 1'b0;
`endif

    // Stage 2: glyph bit for the stored code, blanked off-screen.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= 1'b0;
        end else begin
            out <= (ascii_char[code_q] ^ invert) & in_range_q;
        end
    end

endmodule
